// File: rtl/advanced_counter_if.sv
// advanced_counter_if: groups the tile enable and the Tiny Tapeout style
// pin bundles (ui_in, uio_in, uo_out, uio_out, uio_oe) of advanced_counter.
// master = the side driving the inputs, slave = the counter itself.
interface advanced_counter_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/advanced_counter.sv
// advanced_counter: 8-bit programmable up/down counter with step 1/2/4/8,
// wrap or saturate on overflow, compare register with match flag and
// optional stop-on-match, and a sticky overflow flag.
// Optional macro ADVCNT_PRESCALER_EN adds a 2^PS prescaler on count steps;
// without it the count tick is always asserted and CFG[7:5] is inert.
module advanced_counter (
  input  logic                clk,
  input  logic                rst_n,
  advanced_counter_if.slave   bus
);

  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] cmp_reg;
  logic [7:0] cfg_reg;
  logic       ovf_reg, ovf_next;

  logic [7:0] data;
  logic [1:0] op;
  logic       en, up;
  logic [1:0] stepx;
  logic       sat, stop;
  logic [7:0] step;
  logic [8:0] sum9, diff9;
  logic       hold, qual, tick, do_step;

  assign en    = bus.ui_in[0];
  assign up    = bus.ui_in[1];
  assign op    = bus.ui_in[3:2];
  assign data  = {bus.uio_in[3:0], bus.ui_in[7:4]};
  assign stepx = cfg_reg[1:0];
  assign sat   = cfg_reg[2];
  assign stop  = cfg_reg[3];
  assign step  = 8'd1 << stepx;
  assign sum9  = {1'b0, cnt_reg} + {1'b0, step};
  assign diff9 = {1'b0, cnt_reg} - {1'b0, step};

  // Stop-on-match freezes counting (and the prescaler) while CNT equals CMP.
  assign hold    = stop && (cnt_reg == cmp_reg);
  assign qual    = bus.ena && (op == 2'b00) && en && !hold;
  assign do_step = qual && tick;

`ifdef ADVCNT_PRESCALER_EN
  logic [6:0] pre_reg;
  logic [2:0] ps;
  logic [7:0] pre_top;

  assign ps      = cfg_reg[7:5];
  assign pre_top = (8'd1 << ps) - 8'd1;
  assign tick    = ({1'b0, pre_reg} == pre_top);

  // Prescaler: advances on qualifying count cycles, cleared by CNT/CFG loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_reg <= 7'd0;
    end else if (bus.ena) begin
      if (op == 2'b01 || op == 2'b11) begin
        pre_reg <= 7'd0;
      end else if (qual) begin
        pre_reg <= tick ? 7'd0 : pre_reg + 7'd1;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^bus.uio_in[7:4];
`else
  assign tick = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{bus.uio_in[7:4], cfg_reg[7:4]};
`endif

  // Next counter value and overflow flag for load and count operations.
  always_comb begin
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (op == 2'b01) begin
      cnt_next = data;
      ovf_next = 1'b0;
    end else if (do_step) begin
      if (up) begin
        if (sum9[8]) begin
          cnt_next = sat ? 8'hFF : sum9[7:0];
          ovf_next = 1'b1;
        end else begin
          cnt_next = sum9[7:0];
        end
      end else begin
        if (diff9[8]) begin
          cnt_next = sat ? 8'h00 : diff9[7:0];
          ovf_next = 1'b1;
        end else begin
          cnt_next = diff9[7:0];
        end
      end
    end
  end

  // Register bank; tile enable gates every update, reset overrides all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= 8'h00;
      cmp_reg <= 8'hFF;
      cfg_reg <= 8'h00;
      ovf_reg <= 1'b0;
    end else if (bus.ena) begin
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
      if (op == 2'b10) cmp_reg <= data;
      if (op == 2'b11) cfg_reg <= data;
    end
  end

  assign bus.uo_out  = cnt_reg;
  assign bus.uio_out = {up, ovf_reg, (cnt_reg == 8'h00), (cnt_reg == cmp_reg), 4'h0};
  assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_advanced_counter.sv
// tb_advanced_counter: directed vectors with hand-computed expectations
// for advanced_counter; honours ADVCNT_PRESCALER_EN like the design.
module tb_advanced_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  advanced_counter_if bus ();

  advanced_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] op, input logic [7:0] d, input logic en, input logic up);
    bus.ui_in  = {d[3:0], op, up, en};
    bus.uio_in = {4'hA, d[7:4]};
  endtask

  task automatic wr(input logic [1:0] op, input logic [7:0] d);
    set_in(op, d, 1'b1, 1'b0);
    cyc(1);
  endtask

  task automatic count(input logic up, input int n);
    set_in(2'b00, 8'h00, 1'b1, up);
    cyc(n);
  endtask

  initial begin
    bus.ena = 1'b1;
    set_in(2'b00, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b0;
    cyc(2);
    chk("rst_cnt",   bus.uo_out, 8'h00);
    chk("rst_match", {7'd0, bus.uio_out[4]}, 8'd0);
    chk("rst_zero",  {7'd0, bus.uio_out[5]}, 8'd1);
    chk("rst_ovf",   {7'd0, bus.uio_out[6]}, 8'd0);
    chk("oe",        bus.uio_oe, 8'hF0);
    chk("uio_low",   {4'h0, bus.uio_out[3:0]}, 8'h00);
    rst_n = 1'b1;

    count(1'b1, 5);
    chk("up5_cnt",  bus.uo_out, 8'h05);
    chk("up5_zero", {7'd0, bus.uio_out[5]}, 8'd0);
    chk("up5_ovf",  {7'd0, bus.uio_out[6]}, 8'd0);
    chk("dir_up",   {7'd0, bus.uio_out[7]}, 8'd1);

    wr(2'b01, 8'hFE);
    chk("load_fe", bus.uo_out, 8'hFE);
    count(1'b1, 3);
    chk("wrap_cnt", bus.uo_out, 8'h01);
    chk("wrap_ovf", {7'd0, bus.uio_out[6]}, 8'd1);
    count(1'b1, 2);
    chk("ovf_sticky", {7'd0, bus.uio_out[6]}, 8'd1);
    wr(2'b01, 8'h00);
    chk("ld0_ovf",  {7'd0, bus.uio_out[6]}, 8'd0);
    chk("ld0_zero", {7'd0, bus.uio_out[5]}, 8'd1);

    wr(2'b11, 8'h04);
    wr(2'b01, 8'hFE);
    count(1'b1, 3);
    chk("sat_cnt", bus.uo_out, 8'hFF);
    chk("sat_ovf", {7'd0, bus.uio_out[6]}, 8'd1);
    wr(2'b01, 8'h00);
    count(1'b0, 1);
    chk("sat_dn_cnt", bus.uo_out, 8'h00);
    chk("sat_dn_ovf", {7'd0, bus.uio_out[6]}, 8'd1);

    wr(2'b11, 8'h03);
    wr(2'b01, 8'h04);
    count(1'b0, 1);
    chk("step8_cnt", bus.uo_out, 8'hFC);
    chk("step8_ovf", {7'd0, bus.uio_out[6]}, 8'd1);
    chk("dir_dn",    {7'd0, bus.uio_out[7]}, 8'd0);
    count(1'b0, 1);
    chk("step8_2", bus.uo_out, 8'hF4);

    wr(2'b10, 8'd10);
    wr(2'b11, 8'h08);
    wr(2'b01, 8'd8);
    count(1'b1, 5);
    chk("stop_cnt",   bus.uo_out, 8'd10);
    chk("stop_match", {7'd0, bus.uio_out[4]}, 8'd1);
    wr(2'b10, 8'd20);
    chk("cmp20_match", {7'd0, bus.uio_out[4]}, 8'd0);
    chk("cmp20_cnt",   bus.uo_out, 8'd10);
    count(1'b1, 1);
    chk("resume_cnt", bus.uo_out, 8'd11);

    bus.ena = 1'b0;
    set_in(2'b01, 8'h55, 1'b1, 1'b1);
    cyc(2);
    chk("ena0_cnt", bus.uo_out, 8'd11);
    bus.ena = 1'b1;

    wr(2'b11, 8'h00);
    count(1'b1, 3);
    chk("pre_rst_cnt", bus.uo_out, 8'd14);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    chk("midrst_cnt", bus.uo_out, 8'h00);
    count(1'b1, 2);
    chk("after_rst_cnt", bus.uo_out, 8'h02);
    wr(2'b01, 8'hFF);
    chk("midrst_cmp_ff", {7'd0, bus.uio_out[4]}, 8'd1);

    wr(2'b11, 8'h40);
    wr(2'b01, 8'h00);
    count(1'b1, 8);
`ifdef ADVCNT_PRESCALER_EN
    chk("ps2_cnt", bus.uo_out, 8'd2);
`else
    chk("ps2_cnt", bus.uo_out, 8'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/advanced_counter.md
# advanced_counter

8-bit programmable up/down counter. It supports a selectable step size, wrap or saturate overflow handling, a compare register with a match flag and optional stop-on-match, and a sticky overflow flag. It is the top-level user block of the Tiny Tapeout tile. All I/O goes through the standard `ui_in`/`uo_out`/`uio_*` pins.

## Interface
- No parameters.
- Reset is synchronous and active-low; one clock.
- `clk`  in  1  — the single clock; all state updates on the rising edge.
- `rst_n`  in  1  — synchronous active-low reset.
- `ena`  in  1  — tile enable. When 0, all state holds.
- `ui_in`  in  8  — control and data:
  - [0] EN — count enable.
  - [1] UP — direction, 1 = up.
  - [3:2] OP — operation select.
  - [7:4] D[3:0] — low data nibble.
- `uio_in`  in  8  — [3:0] D[7:4], the high data nibble. Bits [7:4] are ignored.
- `uo_out`  out  8  — counter value CNT, registered.
- `uio_out`  out  8  — status and tie-offs:
  - [4] MATCH
  - [5] ZERO
  - [6] OVF
  - [7] DIR
  - [3:0] tied to 0.
- `uio_oe`  out  8  — constant 8'hF0.

## Operation
- Data word D = {uio_in[3:0], ui_in[7:4]}.
- Internal registers:
  - CNT[7:0]
  - CMP[7:0]
  - CFG[7:0]: [1:0] STEPX, [2] SAT, [3] STOP, [7:5] PS
  - OVF
  - PRE[6:0], the prescaler.
- OP decode, acted on only when ena=1:
  - 00 — count.
  - 01 — CNT←D; OVF←0; PRE←0.
  - 10 — CMP←D.
  - 11 — CFG←D; PRE←0.
- Load operations ignore EN.
- Count step: step = 1<<STEPX, giving 1, 2, 4 or 8. A count step occurs when all of the following hold:
  - OP=00 and EN=1;
  - the prescaler tick is asserted;
  - not (STOP=1 and CNT==CMP).
- Up arithmetic: 9-bit sum CNT+step.
  - Carry with SAT=0: CNT←sum mod 256, OVF←1.
  - Carry with SAT=1: CNT←255, OVF←1.
  - No carry: CNT←sum.
- Down arithmetic: CNT−step.
  - Borrow with SAT=0: CNT wraps mod 256, OVF←1.
  - Borrow with SAT=1: CNT←0, OVF←1.
  - No borrow: CNT←difference.
- SAT=1 at 255 up (or at 0 down): CNT holds and OVF←1.
- OVF is sticky. It clears only on reset or OP=01.
- Status outputs are combinational from the registers: MATCH = (CNT==CMP); ZERO = (CNT==0); OVF = the register; DIR = ui_in[1].
- Stop-on-match: with STOP=1, counting freezes while CNT==CMP. It resumes after OP=01, OP=10 or OP=11 changes the condition.

## Timing
- All register updates land on the rising clk edge. uo_out and flags reflect the new value one cycle after the qualifying input.
- No handshake. Inputs are sampled every edge.
- rst_n=0 has priority over ena and OP. Reset values:
  - CNT=0, CMP=8'hFF, CFG=0 (step 1, wrap, no stop, PS=0), OVF=0, PRE=0.
  - Outputs after reset: uo_out=0, MATCH=0, ZERO=1, OVF=0.
- ena=0: no register changes, including PRE. Outputs still driven.
- Reset asserted mid-count: state is cleared on that edge; counting restarts from 0 after release.

## Configuration
- Macro `ADVCNT_PRESCALER_EN`.
- Defined:
  - Tick is asserted when PRE == 2^PS−1.
  - On each qualifying cycle (OP=00, EN=1, ena=1), PRE wraps to 0 on tick, else increments.
  - CNT therefore advances once per 2^PS enabled cycles (PS 0–7).
  - PRE does not advance while stop-on-match holds.
- Undefined:
  - PRE is not implemented and the tick is constant 1.
  - CFG[7:5] are still stored but have no effect.

## Test plan
- Reset, then EN=1, UP=1, OP=00 for 5 cycles → uo_out=5. ZERO=0, OVF=0.
- Load CNT=8'hFE (OP=01, D=FE). Then count up with step 1 for 3 cycles: SAT=0 gives CNT=01 with OVF=1; SAT=1 gives CNT=FF with OVF=1. Then load 0 → OVF=0.
- CFG=8'h03 (step 8), CNT=4, count down 1 cycle → CNT=8'hFC, OVF=1.
- CMP=10, CFG=8'h08 (STOP), CNT=8, count up 5 cycles → CNT=10 and holds, MATCH=1. Write CMP=20 → counting resumes.
- ena=0 with EN=1 and OP=01 applied → CNT unchanged. Reset asserted mid-count → next cycle uo_out=0, CMP=FF.
- With `ADVCNT_PRESCALER_EN`: CFG=8'h40 (PS=2), count up 8 cycles from 0 → CNT=2. Without the macro → CNT=8.
